// File: rtl/rv32i_types.sv
// Shared RV32 datapath types: multiply-op encoding and operand-signedness helpers.
package rv32i_types;

    localparam int MUL_OP_W = 2;

    typedef enum logic [MUL_OP_W-1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    // rs1 is treated as signed for MULH and MULHSU
    function automatic logic mul_op_is_signed_a(input mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    // rs2 is treated as signed for MULH only
    function automatic logic mul_op_is_signed_b(input mul_op_e op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/mul_accum_stage.sv
// One partial-product accumulation stage of the pipelined multiplier.
// Adds |a| * (next CH-bit chunk of |b|) shifted to this stage's bit offset
// into the running 2*WIDTH accumulator. The LAST stage also applies the sign
// and selects the requested product half, and its result/tag registers are
// the block's output registers.
module mul_accum_stage
    import rv32i_types::*;
#(
    parameter int WIDTH     = 32,
    parameter int CH        = 8,
    parameter int STAGE_IDX = 1,
    parameter int TAG_W     = 6,
    parameter bit LAST      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 advance,
    input  logic                 clear,
    input  logic                 valid_in,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 neg_in,
    input  mul_op_e              op_in,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 valid_q,
    output logic [2*WIDTH-1:0]   acc_q,
    output logic [WIDTH-1:0]     a_q,
    output logic [WIDTH-1:0]     b_q,
    output logic                 neg_q,
    output mul_op_e              op_q,
    output logic [TAG_W-1:0]     tag_q,
    output logic [WIDTH-1:0]     result_q
);

    localparam int PW     = 2 * WIDTH;
    localparam int OFFSET = (STAGE_IDX - 1) * CH;

    logic             load;
    logic [CH-1:0]    chunk;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    acc_sum;
    logic [WIDTH-1:0] b_next;

    // Apply the sign to the magnitude product and pick the requested half
    function automatic logic [WIDTH-1:0] finalize(input logic [PW-1:0] sum,
                                                  input logic          neg,
                                                  input mul_op_e       op);
        logic [PW-1:0] prod;
        prod = neg ? (~sum + {{(PW-1){1'b0}}, 1'b1}) : sum;
        return (op == MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
    endfunction

    // Data only moves when the pipe advances with a real op; a flush wins
    assign load = advance && valid_in && !clear;

    // Partial product for this stage's chunk; remaining |b| bits shift down,
    // so a short final chunk is naturally zero-extended
    always_comb begin
        chunk   = b_in[CH-1:0];
        pp      = ({{WIDTH{1'b0}}, a_in} * {{(PW-CH){1'b0}}, chunk}) << OFFSET;
        acc_sum = acc_in + pp;
        b_next  = b_in >> CH;
    end

    // Stage valid bit: bubbles propagate, stall holds, flush clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q <= valid_in;
        end
    end

    // Accumulator and travelling operand state, held on stall and bubbles
    always_ff @(posedge clk) begin
        if (load) begin
            acc_q <= acc_sum;
            a_q   <= a_in;
            b_q   <= b_next;
            neg_q <= neg_in;
            op_q  <= op_in;
        end
    end

    if (LAST) begin : g_last
        // Output register: visible result and tag, cleared by reset
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_q    <= '0;
                result_q <= '0;
            end else if (load) begin
                tag_q    <= tag_in;
                result_q <= finalize(acc_sum, neg_in, op_in);
            end
        end
    end else begin : g_mid
        // Tag travels with the op through intermediate stages
        always_ff @(posedge clk) begin
            if (load) begin
                tag_q <= tag_in;
            end
        end
        assign result_q = '0;
    end

endmodule

// File: rtl/pipelined_multiplier.sv
// Fully pipelined RV32M-style multiplier (MUL/MULH/MULHSU/MULHU), one op per
// cycle, latency STAGES, in-order, with a tag carried alongside each op.
// Optional build macro MUL_FLUSH_EN adds a synchronous flush input that
// discards everything in flight.
module pipelined_multiplier
    import rv32i_types::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MUL_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  mul_op_e          in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CH = (WIDTH + STAGES - 1) / STAGES;
    localparam int PW = 2 * WIDTH;

    // Index 0 is the combinational preprocessed input; k is stage k's registers
    logic             valid_s  [0:STAGES];
    logic [PW-1:0]    acc_s    [0:STAGES];
    logic [WIDTH-1:0] a_s      [0:STAGES];
    logic [WIDTH-1:0] b_s      [0:STAGES];
    logic             neg_s    [0:STAGES];
    mul_op_e          op_s     [0:STAGES];
    logic [TAG_W-1:0] tag_s    [0:STAGES];
    logic [WIDTH-1:0] result_s [0:STAGES];

    logic clear;
    logic stall;
    logic advance;
    logic a_neg;
    logic b_neg;

`ifdef MUL_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    // Whole pipe, output register included, freezes while the result is refused
    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall && !clear;

    // Operand preprocessing: effective signs, magnitudes and result sign
    always_comb begin
        a_neg       = mul_op_is_signed_a(in_op) && in_a[WIDTH-1];
        b_neg       = mul_op_is_signed_b(in_op) && in_b[WIDTH-1];
        valid_s[0]  = in_valid && in_ready;
        acc_s[0]    = '0;
        a_s[0]      = a_neg ? (~in_a + {{(WIDTH-1){1'b0}}, 1'b1}) : in_a;
        b_s[0]      = b_neg ? (~in_b + {{(WIDTH-1){1'b0}}, 1'b1}) : in_b;
        neg_s[0]    = (a_neg ^ b_neg) && (in_a != '0) && (in_b != '0);
        op_s[0]     = in_op;
        tag_s[0]    = in_tag;
        result_s[0] = '0;
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        mul_accum_stage #(
            .WIDTH     (WIDTH),
            .CH        (CH),
            .STAGE_IDX (k),
            .TAG_W     (TAG_W),
            .LAST      (k == STAGES)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .advance  (advance),
            .clear    (clear),
            .valid_in (valid_s[k-1]),
            .acc_in   (acc_s[k-1]),
            .a_in     (a_s[k-1]),
            .b_in     (b_s[k-1]),
            .neg_in   (neg_s[k-1]),
            .op_in    (op_s[k-1]),
            .tag_in   (tag_s[k-1]),
            .valid_q  (valid_s[k]),
            .acc_q    (acc_s[k]),
            .a_q      (a_s[k]),
            .b_q      (b_s[k]),
            .neg_q    (neg_s[k]),
            .op_q     (op_s[k]),
            .tag_q    (tag_s[k]),
            .result_q (result_s[k])
        );
    end

    // Busy whenever any stage, including the output stage, holds an op
    always_comb begin
        busy = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            busy = busy | valid_s[k];
        end
    end

    assign out_valid  = valid_s[STAGES];
    assign out_result = result_s[STAGES];
    assign out_tag    = tag_s[STAGES];

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Scoreboard bench for pipelined_multiplier: expected results come from a
// plain 64-bit arithmetic model; a negedge monitor records accepted ops and
// compares every retired result in order.
module tb_pipelined_multiplier;
    import rv32i_types::*;

    localparam int W  = 32;
    localparam int ST = 4;
    localparam int TW = 6;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    mul_op_e       in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          busy;

    typedef struct packed {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   retired  = 0;
    int   accepted = 0;

    pipelined_multiplier #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef MUL_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full product of sign/zero-extended operands, then pick a half
    function automatic logic [W-1:0] ref_mul(input mul_op_e op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint      xa;
        longint      xb;
        logic [63:0] p;
        xa = (op == MULH || op == MULHSU) ? longint'($signed(a)) : longint'({32'b0, a});
        xb = (op == MULH)                 ? longint'($signed(b)) : longint'({32'b0, b});
        p  = xa * xb;
        return (op == MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom % 6)
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshake rule, retire comparison, then record new acceptances
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready) && !flush);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=0x%0h tag=%0d required=none",
                             out_result, out_tag);
                end else begin
                    e = sb.pop_front();
                    check("result", out_result, e.res);
                    check("tag", out_tag, e.tag);
                    retired++;
                end
            end
            if (in_valid && in_ready) begin
                e.res = ref_mul(in_op, in_a, in_b);
                e.tag = in_tag;
                sb.push_back(e);
                accepted++;
            end
        end
    end

    // Offer one op and hold it until accepted (bounded)
    task automatic issue(input mul_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
        int n;
        bit took;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        n        = 0;
        took     = 1'b0;
        while (!took && n < 64) begin
            @(negedge clk);
            took = in_ready;
            tick();
            n++;
        end
        if (!took) check("issue_accepted", took, 1);
    endtask

    task automatic run_one(input string name, input mul_op_e op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TW-1:0] tag,
                           input logic [W-1:0] req, output int lat);
        issue(op, a, b, tag);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 32) begin
            tick();
            lat++;
        end
        check({name, "_valid"}, out_valid, 1);
        check(name, out_result, req);
        check({name, "_tag"}, out_tag, tag);
        tick();
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", sb.size(), 0);
        tick();
        tick();
        check("drain_busy", busy, 0);
    endtask

    initial begin
        int lat;
        int r0;
        int a0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_op     = MUL;
        in_a      = 32'h0000_1234;
        in_b      = 32'h0000_0005;
        in_tag    = 6'd3;
        out_ready = 1'b1;

        // Reset held with an op offered
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        tick();

        // Latency and directed corners
        run_one("lat_mul", MUL, 32'd7, 32'd6, 6'd5, 32'd42, lat);
        check("latency", lat, ST);
        run_one("mulh_minmin", MULH, 32'h8000_0000, 32'h8000_0000, 6'd1, 32'h4000_0000, lat);
        run_one("mulhsu_m1", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 32'hFFFF_FFFF, lat);
        run_one("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 32'hFFFF_FFFE, lat);
        run_one("mul_zero", MUL, 32'hFFFF_FFFF, 32'h0, 6'd4, 32'h0, lat);
        run_one("mulh_neg", MULH, 32'hFFFF_FFFE, 32'h0000_0003, 6'd6, 32'hFFFF_FFFF, lat);

        // Back-to-back with a 3-cycle backpressure window mid-stream
        r0 = retired;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    issue(mul_op_e'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), TW'(i + 10));
                in_valid = 1'b0;
            end
            begin
                repeat (5) tick();
                out_ready = 1'b0;
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain();
        check("b2b_count", retired - r0, 10);

        // Randomised traffic with random backpressure
        r0 = retired;
        a0 = accepted;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_op     = mul_op_e'($urandom_range(0, 3));
            in_a      = rand_opnd();
            in_b      = rand_opnd();
            in_tag    = TW'(i);
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        drain();
        check("rand_count", retired - r0, accepted - a0);

        // Asynchronous reset with three ops in flight
        for (int i = 0; i < 3; i++) issue(MULHU, $urandom, $urandom, TW'(i + 40));
        in_valid = 1'b0;
        check("mf_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mf_out_valid", out_valid, 0);
        check("mf_busy", busy, 0);
        check("mf_out_result", out_result, 0);
        check("mf_out_tag", out_tag, 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mf_no_stale", out_valid, 0);
        end
        run_one("mf_after", MUL, 32'hFFFF_FFFD, 32'h0000_0005, 6'd33, 32'hFFFF_FFF1, lat);

`ifdef MUL_FLUSH_EN
        // Flush with three in flight and a new op offered
        for (int i = 0; i < 3; i++) issue(MUL, $urandom, $urandom, TW'(i + 50));
        in_valid = 1'b1;
        in_op    = MUL;
        in_a     = 32'd9;
        in_b     = 32'd9;
        in_tag   = 6'd60;
        flush    = 1'b1;
        sb.delete();
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("flush_no_result", out_valid, 0);
        end
        run_one("flush_after", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd61, 32'h0, lat);
`endif

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound on the whole run
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_multiplier.md
Name: pipelined_multiplier

Overview:
- Parametrised, fully pipelined integer multiplier for the neuron datapath; successor to the fixed 32-bit, single-op-in-flight multiplier.
- Accepts one operation per cycle under valid/ready, supports all four RV32M multiply flavours, and carries a tag through the pipe.
- Sits between issue logic and writeback. The product is built incrementally across STAGES registered partial-product accumulation stages.

Parameters:
- WIDTH, 32: operand and result width in bits; even, >= 8.
- STAGES, 4: pipeline depth and latency; 1 <= STAGES <= WIDTH.
- TAG_W, 6: width of the opaque tag carried with each op.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- in_op  in  2  mul_op_e: MUL=00, MULH=01, MULHSU=10, MULHU=11
- in_a  in  WIDTH  multiplicand (rs1)
- in_b  in  WIDTH  multiplier (rs2)
- in_tag  in  TAG_W  opaque ID, returned unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  selected half of the 2*WIDTH product
- out_tag  out  TAG_W  tag of the op in out_result
- busy  out  1  any stage holds a valid op

Behaviour:
- Reset (async assert, sync-deassert assumed upstream): all stage valid bits 0, out_valid=0, out_result=0, out_tag=0, busy=0; in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight ops; no result is emitted for them.
- Accept when in_valid && in_ready. Stall = out_valid && !out_ready. in_ready = !stall.
  - While stalled, every stage, including the output register, holds.
  - Bubbles travel with the pipe; they are not collapsed.
- Latency: an op accepted at cycle T presents out_valid=1 at T+STAGES if no stall occurs. Throughput is 1 op/cycle; ops retire in order.
- Input preprocessing, combinational before stage 1:
  - Signed operands: a is signed for MULH and MULHSU; b is signed for MULH only.
  - Compute magnitudes |a| and |b| as unsigned WIDTH-bit values; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - neg = sign(a_eff) XOR sign(b_eff), forced to 0 if either operand is zero.
- Stage k (1..STAGES): CH = ceil(WIDTH/STAGES). Stage k adds |a| * |b|[chunk k-1] << ((k-1)*CH) into a 2*WIDTH accumulator.
  - The last chunk is zero-extended where WIDTH is not a multiple of STAGES.
  - |a|, the remaining |b| bits, neg, op and tag travel with the op.
- Final stage: if neg, product = two's complement of the accumulator in 2*WIDTH bits.
  - MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits.
  - The result and tag are registered into out_result and out_tag.
- Arithmetic corner cases:
  - MULH of min*min = 2^(2*WIDTH-2), so the high half is 0x40000000 for WIDTH=32.
  - MULHSU of -1 * 0xFFFFFFFF has high half 0xFFFFFFFF.
- in_op values are all legal; there is no default/illegal case.
- out_result and out_tag hold their last value while out_valid=0.
- Simultaneous accept and retire in the same cycle is allowed and does not stall.

Optional Feature:
- Macro: MUL_FLUSH_EN
- With the macro: an extra input port flush (1 bit, synchronous) is present. In a cycle with flush=1:
  - All stage valid bits and out_valid clear at the next edge.
  - in_ready is forced to 0 that cycle, so an op offered that cycle is not accepted.
  - busy is 0 in the following cycle.
- Without the macro: no flush port, and the pipe drains only through out_ready.

Decomposition:
- The shared package (rv32i_types) gains:
  - mul_op_e typedef
  - op encodings
  - a mul_op_is_signed_a/b helper function
- One sub-module, mul_accum_stage: one partial-product accumulation stage.
  - Parametrised by WIDTH, CH and stage index; holds a valid bit and hold-on-stall registers.
  - The top generate-instantiates it STAGES times.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, busy=0, out_result=0. After release, in_ready=1.
- Latency: MUL 7*6, tag 5, STAGES=4, out_ready=1 -> out_valid exactly 4 cycles later with result 42 and tag 5.
- Signed corners:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MUL 0xFFFFFFFF*0 -> 0.
- Back-to-back with backpressure: 10 ops on consecutive cycles, out_ready low for 3 cycles mid-stream -> all 10 results in order, correct tags, no loss or duplication, in_ready=0 exactly while stalled.
- Async reset mid-flight: drop rst_n with 3 ops in the pipe, off a clock edge -> outputs clear immediately; no stale result after release.
- MUL_FLUSH_EN build: assert flush with 3 in flight and in_valid=1 -> no results emitted, the offered op is not accepted, busy=0 next cycle; an op issued afterwards returns correctly.
